// File: rtl/stream_join.sv
// stream_join: two-channel synchronising join stage.
// Each input channel feeds its own FIFO; one output beat {ch1, ch0} is formed
// when both FIFOs hold a beat. The output is a registered EMPTY/HOLD stage
// with valid/ready backpressure. Pairing is strictly in arrival order.
// Optional feature macro: STREAM_JOIN_STAT_EN adds the 16-bit join_cnt
// handshake counter port.
module stream_join #(
    parameter int DW    = 11,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src0_valid,
    output logic              src0_ready,
    input  logic [DW-1:0]     src0_data,
    input  logic              src1_valid,
    output logic              src1_ready,
    input  logic [DW-1:0]     src1_data,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic [2*DW-1:0]   dst_data
`ifdef STREAM_JOIN_STAT_EN
    ,
    output logic [15:0]       join_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Full when the index bits match but the wrap bits differ.
    function automatic logic fifo_full(input logic [AW:0] wptr, input logic [AW:0] rptr);
        return (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    endfunction

    // Empty when both pointers, including the wrap bit, are equal.
    function automatic logic fifo_empty(input logic [AW:0] wptr, input logic [AW:0] rptr);
        return (wptr == rptr);
    endfunction

    logic [DW-1:0]   r_mem0 [DEPTH];
    logic [DW-1:0]   r_mem1 [DEPTH];
    logic [AW:0]     r_wptr0;
    logic [AW:0]     r_rptr0;
    logic [AW:0]     r_wptr1;
    logic [AW:0]     r_rptr1;
    state_t          r_state;
    logic            r_dst_valid;
    logic [2*DW-1:0] r_dst_data;

    logic            w_full0;
    logic            w_full1;
    logic            w_empty0;
    logic            w_empty1;
    logic            w_push0;
    logic            w_push1;
    logic            w_fire;
    logic [DW-1:0]   w_head0;
    logic [DW-1:0]   w_head1;

    assign w_full0  = fifo_full(r_wptr0, r_rptr0);
    assign w_full1  = fifo_full(r_wptr1, r_rptr1);
    assign w_empty0 = fifo_empty(r_wptr0, r_rptr0);
    assign w_empty1 = fifo_empty(r_wptr1, r_rptr1);

    // Ready depends on FIFO occupancy only, never on valid or the other side.
    assign src0_ready = ~w_full0;
    assign src1_ready = ~w_full1;

    assign w_push0 = src0_valid & ~w_full0;
    assign w_push1 = src1_valid & ~w_full1;

    assign w_head0 = r_mem0[r_rptr0[AW-1:0]];
    assign w_head1 = r_mem1[r_rptr1[AW-1:0]];

    // A pair leaves both FIFOs together when the output slot is free or draining.
    assign w_fire = ~w_empty0 & ~w_empty1 & ((r_state == ST_EMPTY) | dst_ready);

    assign dst_valid = r_dst_valid;
    assign dst_data  = r_dst_data;

    // Channel 0 storage; payload needs no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_mem0[r_wptr0[AW-1:0]] <= src0_data;
        end
    end

    // Channel 1 storage.
    always_ff @(posedge clk) begin
        if (w_push1) begin
            r_mem1[r_wptr1[AW-1:0]] <= src1_data;
        end
    end

    // Channel 0 pointers: write on accept, read on fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr0 <= {(AW+1){1'b0}};
            r_rptr0 <= {(AW+1){1'b0}};
        end else begin
            if (w_push0) begin
                r_wptr0 <= r_wptr0 + C_PTR_ONE;
            end
            if (w_fire) begin
                r_rptr0 <= r_rptr0 + C_PTR_ONE;
            end
        end
    end

    // Channel 1 pointers: write on accept, read on fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr1 <= {(AW+1){1'b0}};
            r_rptr1 <= {(AW+1){1'b0}};
        end else begin
            if (w_push1) begin
                r_wptr1 <= r_wptr1 + C_PTR_ONE;
            end
            if (w_fire) begin
                r_rptr1 <= r_rptr1 + C_PTR_ONE;
            end
        end
    end

    // Output register FSM: load a joined beat on fire, drop valid once taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_dst_valid <= 1'b0;
            r_dst_data  <= {(2*DW){1'b0}};
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_fire) begin
                        r_state     <= ST_HOLD;
                        r_dst_valid <= 1'b1;
                        r_dst_data  <= {w_head1, w_head0};
                    end
                end
                ST_HOLD: begin
                    if (w_fire) begin
                        r_state     <= ST_HOLD;
                        r_dst_valid <= 1'b1;
                        r_dst_data  <= {w_head1, w_head0};
                    end else if (dst_ready) begin
                        r_state     <= ST_EMPTY;
                        r_dst_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_dst_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef STREAM_JOIN_STAT_EN
    logic [15:0] r_join_cnt;

    // Count completed output handshakes, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_join_cnt <= 16'h0000;
        end else if (r_dst_valid && dst_ready) begin
            r_join_cnt <= r_join_cnt + 16'h0001;
        end
    end

    assign join_cnt = r_join_cnt;
`endif

endmodule

// File: tb/tb_stream_join.sv
// Testbench for stream_join: directed scenarios plus a random stress phase,
// each cycle compared against a queue-based behavioural model.
module tb_stream_join;

    localparam int DW    = 11;
    localparam int DEPTH = 4;
    localparam int OW    = 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          src0_valid;
    logic          src0_ready;
    logic [DW-1:0] src0_data;
    logic          src1_valid;
    logic          src1_ready;
    logic [DW-1:0] src1_data;
    logic          dst_valid;
    logic          dst_ready;
    logic [OW-1:0] dst_data;
`ifdef STREAM_JOIN_STAT_EN
    logic [15:0]   join_cnt;
`endif

    stream_join #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .src0_valid (src0_valid),
        .src0_ready (src0_ready),
        .src0_data  (src0_data),
        .src1_valid (src1_valid),
        .src1_ready (src1_ready),
        .src1_data  (src1_data),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .dst_data   (dst_data)
`ifdef STREAM_JOIN_STAT_EN
        ,
        .join_cnt   (join_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model state
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          m_valid = 1'b0;
    logic [OW-1:0] m_data  = '0;
    logic [15:0]   m_cnt   = 16'h0000;
    bit            m_known = 1'b0;
    bit            g_acc0;
    bit            g_acc1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1, input logic rdy);
        src0_valid = v0;
        src0_data  = d0;
        src1_valid = v1;
        src1_data  = d1;
        dst_ready  = rdy;
    endtask

    // One clock: check readys, advance the model, clock the DUT, check outputs.
    task automatic tick();
        logic r0;
        logic r1;
        logic hs;
        logic fire;
        logic [DW-1:0] h0;
        logic [DW-1:0] h1;
        r0 = (q0.size() != DEPTH);
        r1 = (q1.size() != DEPTH);
        g_acc0 = 1'b0;
        g_acc1 = 1'b0;
        if (m_known) begin
            chk("src0_ready", {31'd0, src0_ready}, {31'd0, r0});
            chk("src1_ready", {31'd0, src1_ready}, {31'd0, r1});
        end
        if (!rst) begin
            q0.delete();
            q1.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_cnt   = 16'h0000;
            m_known = 1'b1;
        end else begin
            hs   = m_valid && dst_ready;
            fire = (q0.size() > 0) && (q1.size() > 0) && (!m_valid || dst_ready);
            if (hs) m_cnt = m_cnt + 16'h0001;
            if (fire) begin
                h0 = q0.pop_front();
                h1 = q1.pop_front();
                m_data  = {h1, h0};
                m_valid = 1'b1;
            end else if (hs) begin
                m_valid = 1'b0;
            end
            if (src0_valid && r0) begin q0.push_back(src0_data); g_acc0 = 1'b1; end
            if (src1_valid && r1) begin q1.push_back(src1_data); g_acc1 = 1'b1; end
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("dst_valid", {31'd0, dst_valid}, {31'd0, m_valid});
            chk("dst_data", {10'd0, dst_data}, {10'd0, m_data});
`ifdef STREAM_JOIN_STAT_EN
            chk("join_cnt", {16'd0, join_cnt}, {16'd0, m_cnt});
`endif
        end
    endtask

    initial begin
        logic [DW-1:0] s0;
        logic [DW-1:0] s1;

        // reset
        rst = 1'b0;
        drive(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        chk("rst_valid", {31'd0, dst_valid}, 32'd0);
        chk("rst_data", {10'd0, dst_data}, 32'd0);
        chk("rst_rdy0", {31'd0, src0_ready}, 32'd1);
        chk("rst_rdy1", {31'd0, src1_ready}, 32'd1);
`ifdef STREAM_JOIN_STAT_EN
        chk("rst_cnt", {16'd0, join_cnt}, 32'd0);
`endif

        // balanced stream
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 11'(1 + i), 1'b1, 11'(257 + i), 1'b1);
            tick();
            if (i == 0) begin
                chk("bal_lat", {31'd0, dst_valid}, 32'd0);
            end else begin
                chk("bal_v", {31'd0, dst_valid}, 32'd1);
                chk("bal_d", {10'd0, dst_data}, {10'd0, 11'(256 + i), 11'(i)});
            end
        end
        drive(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
        tick();
        chk("bal_last", {10'd0, dst_data}, {10'd0, 11'h108, 11'h008});
        tick();
        chk("bal_end", {31'd0, dst_valid}, 32'd0);
`ifdef STREAM_JOIN_STAT_EN
        chk("bal_cnt", {16'd0, join_cnt}, 32'd8);
`endif

        // skew to full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 11'(1 + i), 1'b0, 11'h000, 1'b1);
            tick();
            chk("skew_nv", {31'd0, dst_valid}, 32'd0);
        end
        chk("skew_rdy0", {31'd0, src0_ready}, 32'd0);
        chk("skew_rdy1", {31'd0, src1_ready}, 32'd1);
        drive(1'b1, 11'h005, 1'b1, 11'h201, 1'b1);
        tick();
        chk("skew_nv2", {31'd0, dst_valid}, 32'd0);
        chk("skew_rdy0b", {31'd0, src0_ready}, 32'd0);
        drive(1'b1, 11'h005, 1'b0, 11'h000, 1'b1);
        tick();
        chk("skew_v", {31'd0, dst_valid}, 32'd1);
        chk("skew_d", {10'd0, dst_data}, {10'd0, 11'h201, 11'h001});
        chk("skew_rdy0c", {31'd0, src0_ready}, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 11'h000, 1'b1, 11'(12'h202 + i), 1'b1);
            tick();
        end
        drive(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("skew_last", {10'd0, dst_data}, {10'd0, 11'h205, 11'h005});

        // backpressure
        s0 = 11'h300;
        s1 = 11'h380;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, s0, 1'b1, s1, 1'b0);
            tick();
            if (g_acc0) s0 = s0 + 11'h001;
            if (g_acc1) s1 = s1 + 11'h001;
            if (i >= 1) chk("bp_hold", {10'd0, dst_data}, {10'd0, 11'h380, 11'h300});
        end
        chk("bp_rdy0", {31'd0, src0_ready}, 32'd0);
        chk("bp_rdy1", {31'd0, src1_ready}, 32'd0);
        chk("bp_cnt0", {21'd0, s0}, {21'd0, 11'h305});
        drive(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("bp_drain_v", {31'd0, dst_valid}, 32'd0);
        chk("bp_drain_d", {10'd0, dst_data}, {10'd0, 11'h384, 11'h304});

        // reset mid-operation
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 11'(12'h011 + i), 1'b1, 11'(12'h111 + i), 1'b0);
            tick();
        end
        chk("mr_v", {31'd0, dst_valid}, 32'd1);
        drive(1'b0, 11'h000, 1'b0, 11'h000, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_valid", {31'd0, dst_valid}, 32'd0);
        chk("mr_rdy0", {31'd0, src0_ready}, 32'd1);
        chk("mr_rdy1", {31'd0, src1_ready}, 32'd1);
`ifdef STREAM_JOIN_STAT_EN
        chk("mr_cnt", {16'd0, join_cnt}, 32'd0);
`endif
        drive(1'b1, 11'h021, 1'b1, 11'h121, 1'b1);
        tick();
        drive(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
        tick();
        chk("mr_new", {10'd0, dst_data}, {10'd0, 11'h121, 11'h021});
        tick();
        chk("mr_empty", {31'd0, dst_valid}, 32'd0);

        // random stress
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 11'($urandom), 1'($urandom_range(0, 1)),
                  11'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end
        drive(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        chk("rnd_drain", {31'd0, dst_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_join.md
# stream_join

Two-input synchronising join stage. It consumes the two independent valid/data streams produced by the level-detect drivers on each side (channel 0 and channel 1) and emits one combined beat only when one beat from each channel has arrived. Per-channel FIFOs absorb arrival skew, and a registered output stage with valid/ready backpressure feeds the downstream consumer. It sits directly downstream of the paired stream sources in the join test environment.

## Interface
Parameters:
- `DW`, 11: data width of each input channel.
- `DEPTH`, 4: entries per input FIFO; power of two, 2 to 16.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `src0_valid` in 1: channel 0 beat present.
- `src0_ready` out 1: channel 0 FIFO can accept.
- `src0_data` in DW: channel 0 payload.
- `src1_valid` in 1: channel 1 beat present.
- `src1_ready` out 1: channel 1 FIFO can accept.
- `src1_data` in DW: channel 1 payload.
- `dst_valid` out 1: joined beat present.
- `dst_ready` in 1: downstream accepts.
- `dst_data` out 2*DW: joined payload `{ch1, ch0}`.
- `join_cnt` out 16: completed output handshakes. Present only when `STREAM_JOIN_STAT_EN` is defined.

## Operation
- Channel k write: when `srck_valid && srck_ready`, push `srck_data` into FIFO k.
- `srck_ready = (count_k != DEPTH)`. It is combinational from FIFO state only and never depends on `srck_valid` or on the other channel.
- FIFO k uses read and write pointers of log2(DEPTH)+1 bits, and pointers wrap modulo 2*DEPTH. The FIFO is full when the low bits are equal and the MSBs differ. It is empty when the pointers are equal.
- Output register states: EMPTY (`dst_valid=0`) and HOLD (`dst_valid=1`).
- Fire condition: both FIFOs are non-empty and (state is EMPTY, or `dst_ready=1`).
- On fire:
  - pop the head of both FIFOs in the same cycle;
  - load `dst_data <= {head1, head0}`;
  - go to or stay in HOLD.
- In HOLD with `dst_ready=1` and no fire: go to EMPTY.
- In HOLD with `dst_ready=0`: `dst_data` and `dst_valid` are held stable, and nothing is popped.
- Pairing is strictly in order. The n-th beat of channel 0 always joins the n-th beat of channel 1.
- A channel may run up to DEPTH beats ahead of the other. After that, its `ready` drops until the other channel catches up.

## Timing
- Reset, when `rst=0` at a rising edge:
  - pointers cleared;
  - `dst_valid=0`;
  - `dst_data=0`;
  - `join_cnt=0`;
  - `src0_ready=src1_ready=1` from the cycle after reset.
- Reset during operation discards all FIFO contents and any held output beat. No handshake completes on the reset edge.
- Latency:
  - The last-arriving half of a pair is accepted at edge E.
  - It is visible as FIFO head after E.
  - It fires at E+1, so `dst_valid=1` after E+1.
  - Minimum latency is therefore 2 cycles.
- Throughput is 1 joined beat per cycle when both inputs stream and `dst_ready=1`.
- Simultaneous push and pop on a full FIFO: ready is already 0, so no push occurs. The pop frees one slot, and ready rises the next cycle.
- Simultaneous push and pop on a non-full FIFO: count is unchanged.
- Push into an empty FIFO: the entry cannot be popped in the same cycle. There is no bypass.

## Configuration
- `STREAM_JOIN_STAT_EN` defined:
  - `join_cnt` port exists;
  - it increments by 1 on each cycle with `dst_valid && dst_ready`;
  - it wraps 0xFFFF to 0x0000;
  - it is cleared by reset.
- Not defined: the port and its counter logic are absent, and all other behaviour is identical.

## Test plan
- **Balanced stream.** Drive `src0_data=0x001..0x008` and `src1_data=0x101..0x108`, valid every cycle, `dst_ready=1`.
  - Expect 8 outputs `{0x101,0x001}`..`{0x108,0x008}`.
  - First output 2 cycles after the first pair is accepted, then one per cycle.
  - `join_cnt=8`.
- **Skew to full.** Send 5 beats on channel 0 with channel 1 idle.
  - `src0_ready` drops after 4 accepts; the 5th beat waits.
  - `dst_valid` stays 0.
  - Then send 1 beat on channel 1: expect output `{ch1_0, 0x001}`, and `src0_ready` is back to 1 the following cycle.
- **Backpressure.** Hold `dst_ready=0` for 10 cycles with both channels streaming.
  - `dst_data` is stable throughout.
  - Both readys drop after 4+1 beats are absorbed.
  - On release, all beats drain in order with no loss or duplication.
- **Reset mid-operation.** Apply `rst=0` for 1 cycle with 3 beats in each FIFO and `dst_valid=1`.
  - Next cycle: `dst_valid=0`, both readys 1, `join_cnt=0`.
  - Old beats never appear on the output.
- **Random stress.** Random valid on each channel and random `dst_ready` at 50% for 300 cycles.
  - A scoreboard confirms in-order pairing.
  - `join_cnt` equals the number of observed handshakes modulo 65536.
- **Macro off.** Build without `STREAM_JOIN_STAT_EN` and rerun the balanced stream test.
  - Identical outputs.
  - `join_cnt` is absent.
